// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 constants and the program-loader state encoding.
package sap1_pkg;
  localparam int RAM_DEPTH  = 16;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_FLUSH, ST_DONE} state_e;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: streams DEPTH bytes into the SAP-1 RAM write port, holding the CPU while busy.
// Define RAM_LOADER_CHECKSUM_EN to accept a trailing checksum byte and report err_o.
module ram_loader
  import sap1_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, hs, last;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic err_q, err_d;
`endif
  assign in_ready_o = state_q == ST_LOAD || state_q == ST_CHECK;
  assign busy_o     = in_ready_o || state_q == ST_FLUSH;
  assign done_o     = state_q == ST_DONE;
  assign hs         = in_valid_i && in_ready_o;
  assign last       = addr_q == ADDR_W'(DEPTH - 1);
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
`ifdef RAM_LOADER_CHECKSUM_EN
  assign err_o      = err_q && done_o;
`else
  assign err_o      = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_i) begin
        state_d = ST_LOAD;
        addr_d  = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d   = '0;
        err_d   = 1'b0;
`endif
      end
      ST_LOAD: if (hs) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = in_data_i;
        // the counter parks on the last address instead of wrapping
        addr_d  = last ? addr_q : addr_q + 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + in_data_i;
        state_d = last ? ST_CHECK : ST_LOAD;
`else
        state_d = last ? ST_FLUSH : ST_LOAD;
`endif
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      ST_CHECK: if (hs) begin
        err_d   = (sum_q + in_data_i) != '0;
        state_d = ST_FLUSH;
      end
`endif
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
`ifdef RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized loads checked against a per-cycle write model and a shadow RAM.
module tb_ram_loader;
  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic in_ready_o, we_o, busy_o, done_o, err_o;
  logic [3:0] waddr_o;
  logic [7:0] wdata_o;
  logic [7:0] ram_dut [16];
  logic [7:0] ram_m [16];
  int checks = 0, errors = 0, exp_addr = 0;

  ram_loader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_data_i(in_data_i), .in_ready_o(in_ready_o), .we_o(we_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (we_o) ram_dut[waddr_o] <= wdata_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at a falling edge, step through the rising edge, check at the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic rdy, input logic wr);
    logic pend;
    in_valid_i = v; in_data_i = d; start_i = s;
    chk("in_ready", 32'(in_ready_o), 32'(rdy));
    pend = v && rdy && wr;
    @(negedge clk);
    chk("we", 32'(we_o), 32'(pend));
    if (pend) begin
      chk("waddr", 32'(waddr_o), 32'(exp_addr));
      chk("wdata", 32'(wdata_o), 32'(d));
      ram_m[exp_addr] = d;
      exp_addr++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"},    32'(we_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
    chk({tag, "_err"},   32'(err_o), 0);
    chk({tag, "_ready"}, 32'(in_ready_o), 0);
    chk({tag, "_waddr"}, 32'(waddr_o), 0);
    chk({tag, "_wdata"}, 32'(wdata_o), 0);
  endtask

  // mode 0: continuous, 1: valid toggling, 2: random gaps; restart_at pulses start once mid-load
  task automatic load(input int mode, input int restart_at, input bit bad, input bit fixed);
    logic [7:0] data [16];
    logic [7:0] sum = '0;
    logic v;
    bit restarted = 0;
    int i = 0, n = 0;
    if (fixed) data = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                        8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};
    else foreach (data[k]) data[k] = 8'($urandom);
    exp_addr = 0;
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_done", 32'(done_o), 0);
    chk("start_err", 32'(err_o), 0);
    while (i < 16 && n < 1000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? ~n[0] : 1'($urandom_range(1));
      cyc(v, data[i], i == restart_at && !restarted, 1'b1, 1'b1);
      if (i == restart_at) restarted = 1;
      if (v) begin sum += data[i]; i++; end
      n++;
      chk("load_busy", 32'(busy_o), 1);
      chk("load_done", 32'(done_o), 0);
    end
    chk("byte_budget", i, 16);
`ifdef RAM_LOADER_CHECKSUM_EN
    cyc(1'b1, 8'(-sum) + 8'(bad), 1'b0, 1'b1, 1'b0);
    chk("flush_busy", 32'(busy_o), 1);
    chk("flush_done", 32'(done_o), 0);
`endif
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("done", 32'(done_o), 1);
    chk("done_busy", 32'(busy_o), 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk("err", 32'(err_o), 32'(bad));
`else
    chk("err", 32'(err_o), 0);
`endif
    repeat (2) cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("done_hold", 32'(done_o), 1);
    in_valid_i = 1'b0;
    foreach (ram_m[k]) chk($sformatf("ram%0d", k), 32'(ram_dut[k]), 32'(ram_m[k]));
  endtask

  initial begin
    foreach (ram_dut[k]) begin ram_dut[k] = '0; ram_m[k] = '0; end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    repeat (2) cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    load(0, -1, 1'b0, 1'b1);
    load(1, -1, 1'b0, 1'b0);
    load(2, 7, 1'b0, 1'b0);
    exp_addr = 0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b1);
    chk("pre_rst_busy", 32'(busy_o), 1);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_i = 1'b0;
    load(0, -1, 1'b0, 1'b0);
`ifdef RAM_LOADER_CHECKSUM_EN
    load(2, -1, 1'b1, 1'b0);
    load(0, -1, 1'b0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
